// File: rtl/spi_page_program.sv
`default_nettype none
// ============================================================================
// spi_page_program: buffers host bytes, then issues WREN, Page Program and
// Read-Status polling on a single-lane serial flash, one bit per clk.
// Revision: 1.0
// ============================================================================
module spi_page_program #(
    parameter int MAX_BYTES      = 256,
    parameter int CS_HIGH_CYCLES = 2,
    parameter int POLL_LIMIT     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] address,
    input  logic [8:0]  byte_count,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        DO_from_chip,
    output logic        DI_to_chip,
    output logic        ncs,
    output logic        busy,
    output logic        write_finished,
    output logic        timeout_err,
    output logic        len_err
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int PCW   = $clog2(POLL_LIMIT + 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_LOAD     = 4'd1;
    localparam logic [3:0] c_WREN     = 4'd2;
    localparam logic [3:0] c_GAP1     = 4'd3;
    localparam logic [3:0] c_PP       = 4'd4;
    localparam logic [3:0] c_GAP2     = 4'd5;
    localparam logic [3:0] c_POLL_CMD = 4'd6;
    localparam logic [3:0] c_POLL_RD  = 4'd7;
    localparam logic [3:0] c_GAP3     = 4'd8;
    localparam logic [3:0] c_DONE     = 4'd9;

    localparam logic [7:0]     c_OP_WREN  = 8'h06;
    localparam logic [7:0]     c_OP_PP    = 8'h02;
    localparam logic [7:0]     c_OP_RDSR  = 8'h05;
    localparam logic [15:0]    c_GAP_LAST = 16'(CS_HIGH_CYCLES - 1);
    localparam logic [PCW-1:0] c_POLL_LAST = PCW'(POLL_LIMIT - 1);

    logic [3:0]     state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [23:0]    addr_q, addr_d;
    logic [8:0]     count_q, count_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic           timeout_q, timeout_d;
    logic           len_err_q, len_err_d;
    logic           ncs_q, ncs_d;
    logic           di_q, di_d;
    logic           sync1_q, sync2_q;
    logic           mem_we;
    logic [7:0]     buf_q [MAX_BYTES];

    logic [15:0]      pp_last;
    logic [12:0]      byte_sel;
    logic [2:0]       bit_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       pp_byte;

    assign pp_last = {4'b0, count_q, 3'b000} + 16'd31;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        count_d    = count_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
        len_err_d  = len_err_q;
        mem_we     = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    addr_d     = address;
                    count_d    = byte_count;
                    timeout_d  = 1'b0;
                    len_err_d  = 1'b0;
                    poll_cnt_d = '0;
                    cnt_d      = '0;
                    if (byte_count == 9'd0) begin
                        state_d = c_DONE;
                    end else if (int'(byte_count) > MAX_BYTES) begin
                        len_err_d = 1'b1;
                        state_d   = c_DONE;
                    end else begin
                        state_d = c_LOAD;
                    end
                end
            end
            c_LOAD: begin
                if (data_valid) begin
                    mem_we = 1'b1;
                    if (cnt_q == {7'b0, count_q} - 16'd1) begin
                        state_d = c_WREN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            c_WREN: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd7) begin
                    state_d = c_GAP1;
                    cnt_d   = '0;
                end
            end
            c_GAP1, c_GAP2, c_GAP3: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == c_GAP_LAST) begin
                    state_d = (state_q == c_GAP1) ? c_PP : c_POLL_CMD;
                    cnt_d   = '0;
                end
            end
            c_PP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == pp_last) begin
                    state_d = c_GAP2;
                    cnt_d   = '0;
                end
            end
            c_POLL_CMD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd7) begin
                    state_d = c_POLL_RD;
                    cnt_d   = '0;
                end
            end
            c_POLL_RD: begin
                cnt_d = cnt_q + 16'd1;
                // Only WIP (status bit 0) steers the FSM; it is the synchronized
                // sample present in the last window cycle.
                if (cnt_q == 16'd9) begin
                    cnt_d      = '0;
                    poll_cnt_d = poll_cnt_q + PCW'(1);
                    if (!sync2_q) begin
                        state_d = c_DONE;
                    end else if (poll_cnt_q == c_POLL_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = c_DONE;
                    end else begin
                        state_d = c_GAP3;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Serial outputs are derived from the next state so the first bit and the
    // ncs fall leave on the same edge.
    always_comb begin
        byte_sel = cnt_d[15:3];
        bit_sel  = ~cnt_d[2:0];
        rd_idx   = IDX_W'(byte_sel - 13'd4);
        case (byte_sel)
            13'd0:   pp_byte = c_OP_PP;
            13'd1:   pp_byte = addr_q[23:16];
            13'd2:   pp_byte = addr_q[15:8];
            13'd3:   pp_byte = addr_q[7:0];
            default: pp_byte = buf_q[rd_idx];
        endcase
        ncs_d = 1'b1;
        di_d  = 1'b0;
        case (state_d)
            c_WREN: begin
                ncs_d = 1'b0;
                di_d  = c_OP_WREN[bit_sel];
            end
            c_PP: begin
                ncs_d = 1'b0;
                di_d  = pp_byte[bit_sel];
            end
            c_POLL_CMD: begin
                ncs_d = 1'b0;
                di_d  = c_OP_RDSR[bit_sel];
            end
            c_POLL_RD: begin
                ncs_d = 1'b0;
            end
            default: begin
                ncs_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
            len_err_q  <= 1'b0;
            ncs_q      <= 1'b1;
            di_q       <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
            len_err_q  <= len_err_d;
            ncs_q      <= ncs_d;
            di_q       <= di_d;
            sync1_q    <= DO_from_chip;
            sync2_q    <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_q[cnt_q[IDX_W-1:0]] <= data_in;
        end
    end

    assign data_ready     = (state_q == c_LOAD);
    assign busy           = (state_q != c_IDLE);
    assign write_finished = (state_q == c_DONE);
    assign timeout_err    = timeout_q;
    assign len_err        = len_err_q;
    assign ncs            = ncs_q;
    assign DI_to_chip     = di_q;

endmodule
`default_nettype wire
